acc_dump: RTL and testbench

Parametrised integrate-and-dump accumulator: the multi-bit successor of the single-bit accumulator in the `addac` group. It sums or subtracts `WIDTH`-bit unsigned samples over blocks of `SAMPLES` valid inputs. At the end of each block it emits the block result with a one-cycle strobe and restarts from zero. It sits between a sample source and a downstream consumer (decimator, checker, display logic) that only needs per-block totals.

---
 rtl/acc_pkg.sv | 9 +
 rtl/sat_addsub.sv | 25 ++
 rtl/acc_dump.sv | 78 +++++++
 tb/tb_acc_dump.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the integrate-and-dump accumulator.
package acc_pkg;

    typedef enum logic {ACC, DUMP} acc_state_t;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/sat_addsub.sv
// Width-extended add/subtract with carry/borrow flag and optional clamp.
module sat_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] a,
    input  logic             sub,
    input  logic             sat,
    output logic [WIDTH-1:0] r,
    output logic             flag
);

    logic [WIDTH:0] s;

    always_comb begin
        s    = sub ? ({1'b0, x} - {1'b0, a}) : ({1'b0, x} + {1'b0, a});
        flag = s[WIDTH];
        r    = s[WIDTH-1:0];
        // The top bit alone tells carry from borrow once we know the operation.
        if (sat && flag) begin
            r = sub ? '0 : '1;
        end
    end

endmodule

// File: rtl/acc_dump.sv
// Integrate-and-dump accumulator: sums SAMPLES valid inputs per block, then
// emits the block total with a one-cycle strobe and restarts from zero.
//
//   state | meaning
//   ACC   | accumulating samples of the current block
//   DUMP  | dump_valid high; dump_data/dump_ovf just updated
module acc_dump
    import acc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SAMPLES  = 4,
    parameter int SATURATE = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               a,
    input  logic                           sub,
    output logic [WIDTH-1:0]               y,
    output logic [$clog2(SAMPLES+1)-1:0]   cnt,
    output logic                           ovf,
    output logic                           dump_valid,
    output logic [WIDTH-1:0]               dump_data,
    output logic                           dump_ovf
);

    localparam int CW = $clog2(SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);

    acc_state_t     state;
    logic [WIDTH-1:0] nxt;
    logic           flag;

    sat_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x    (y),
        .a    (a),
        .sub  (sub),
        .sat  (SATURATE == MODE_SAT),
        .r    (nxt),
        .flag (flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            y         <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            dump_data <= '0;
            dump_ovf  <= 1'b0;
        end else begin
            state <= ACC;
            if (clr) begin
                y   <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (in_valid) begin
                if (cnt == LAST) begin
                    state     <= DUMP;
                    dump_data <= nxt;
                    dump_ovf  <= ovf | flag;
                    y         <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    y   <= nxt;
                    cnt <= cnt + CW'(1);
                    ovf <= ovf | flag;
                end
            end
        end
    end

    // The strobe is the state register itself, so it stays glitch-free.
    assign dump_valid = (state == DUMP);

endmodule

// File: tb/tb_acc_dump.sv
// Randomized bench for acc_dump: wrap, saturate and single-sample instances
// driven in parallel and compared against a block-level arithmetic model.
module tb_acc_dump;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic       sub = 1'b0;

    logic [7:0] y_w, y_s, y_1, dd_w, dd_s, dd_1;
    logic [2:0] cnt_w, cnt_s;
    logic [0:0] cnt_1;
    logic       ovf_w, ovf_s, ovf_1, dv_w, dv_s, dv_1, do_w, do_s, do_1;

    int n_cmp = 0;
    int n_err = 0;

    localparam int SAMP [3] = '{4, 4, 1};
    localparam int SATM [3] = '{0, 1, 0};

    int m_y [3], m_cnt [3], m_ovf [3], m_dv [3], m_dd [3], m_do [3];

    always #5 clk = ~clk;

    acc_dump #(.WIDTH(8), .SAMPLES(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .a(a), .sub(sub),
        .y(y_w), .cnt(cnt_w), .ovf(ovf_w), .dump_valid(dv_w), .dump_data(dd_w), .dump_ovf(do_w));

    acc_dump #(.WIDTH(8), .SAMPLES(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .a(a), .sub(sub),
        .y(y_s), .cnt(cnt_s), .ovf(ovf_s), .dump_valid(dv_s), .dump_data(dd_s), .dump_ovf(do_s));

    acc_dump #(.WIDTH(8), .SAMPLES(1), .SATURATE(0)) u_one (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .a(a), .sub(sub),
        .y(y_1), .cnt(cnt_1), .ovf(ovf_1), .dump_valid(dv_1), .dump_data(dd_1), .dump_ovf(do_1));

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_y[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            m_dv[k] = 0; m_dd[k] = 0; m_do[k] = 0;
        end
    endtask

    // One clock edge of block arithmetic, using plain integers.
    task automatic model_step(input int v, input int av, input int sb, input int cl);
        int t, c, nv;
        for (int k = 0; k < 3; k++) begin
            m_dv[k] = 0;
            if (cl != 0) begin
                m_y[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end else if (v != 0) begin
                t  = (sb != 0) ? m_y[k] - av : m_y[k] + av;
                c  = (t < 0 || t > 255) ? 1 : 0;
                if (SATURATE_of(k)) nv = (t < 0) ? 0 : (t > 255) ? 255 : t;
                else                nv = (t + 256) % 256;
                if (m_cnt[k] + 1 == SAMP[k]) begin
                    m_dd[k] = nv; m_do[k] = m_ovf[k] | c; m_dv[k] = 1;
                    m_y[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
                end else begin
                    m_y[k] = nv; m_cnt[k] = m_cnt[k] + 1; m_ovf[k] = m_ovf[k] | c;
                end
            end
        end
    endtask

    function automatic bit SATURATE_of(input int k);
        return SATM[k] != 0;
    endfunction

    task automatic check_all();
        check_val("w.y",   int'(y_w),   m_y[0]);
        check_val("w.cnt", int'(cnt_w), m_cnt[0]);
        check_val("w.ovf", int'(ovf_w), m_ovf[0]);
        check_val("w.dv",  int'(dv_w),  m_dv[0]);
        check_val("w.dd",  int'(dd_w),  m_dd[0]);
        check_val("w.do",  int'(do_w),  m_do[0]);
        check_val("s.y",   int'(y_s),   m_y[1]);
        check_val("s.cnt", int'(cnt_s), m_cnt[1]);
        check_val("s.ovf", int'(ovf_s), m_ovf[1]);
        check_val("s.dv",  int'(dv_s),  m_dv[1]);
        check_val("s.dd",  int'(dd_s),  m_dd[1]);
        check_val("s.do",  int'(do_s),  m_do[1]);
        check_val("1.y",   int'(y_1),   m_y[2]);
        check_val("1.cnt", int'(cnt_1), m_cnt[2]);
        check_val("1.ovf", int'(ovf_1), m_ovf[2]);
        check_val("1.dv",  int'(dv_1),  m_dv[2]);
        check_val("1.dd",  int'(dd_1),  m_dd[2]);
        check_val("1.do",  int'(do_1),  m_do[2]);
    endtask

    // Inputs are only active for the one edge being modelled.
    task automatic drive(input int v, input int av, input int sb, input int cl);
        @(negedge clk);
        in_valid = (v != 0); a = 8'(av); sub = (sb != 0); clr = (cl != 0);
        @(posedge clk);
        model_step(v, av, sb, cl);
        #1;
        in_valid = 1'b0; clr = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;

        // Wrap vs saturate on 100,100,100,10
        drive(1, 100, 0, 0);
        drive(1, 100, 0, 0);
        drive(1, 100, 0, 0);
        check_val("plan_wrap_y3", int'(y_w), 44);
        check_val("plan_sat_y3", int'(y_s), 255);
        drive(1, 10, 0, 0);
        check_val("plan_wrap_dump", int'(dd_w), 54);
        check_val("plan_sat_dump", int'(dd_s), 255);
        check_val("plan_dump_ovf", int'(do_w), 1);
        check_val("plan_dv_hi", int'(dv_w), 1);
        idle(1);
        check_val("plan_dv_lo", int'(dv_w), 0);

        // Subtract below zero
        drive(1, 5, 1, 0);
        check_val("plan_sub_wrap", int'(y_w), 251);
        check_val("plan_sub_sat", int'(y_s), 0);
        check_val("plan_sub_ovf", int'(ovf_s), 1);
        drive(0, 0, 0, 1);

        // Gapped input
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 0, 0);
            idle(2);
        end
        check_val("plan_gap_dump", int'(dd_w), 10);
        check_val("plan_gap_ovf", int'(do_w), 0);

        // clr with a valid sample on the last slot of the block
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 7, 0, 1);
        check_val("plan_clr_dv", int'(dv_w), 0);
        check_val("plan_clr_keep", int'(dd_w), 10);

        // Asynchronous reset between edges
        drive(1, 9, 0, 0);
        drive(1, 9, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
        check_val("plan_rst_dump", int'(dd_w), 4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0) ? 1 : 0,
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
